// File: rtl/alu_serial_if.sv
// Handshake and operand/result bundle for the bit-serial ALU.
`timescale 1ns/1ps
interface alu_serial_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             inva;
  logic             ena;
  logic             enb;
  logic [1:0]       f;
  logic             cin;
  logic             use_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output in_valid, a, b, inva, ena, enb, f, cin, use_acc, out_ready,
    input  in_ready, out_valid, result, cout, zero, neg, ovf
  );

  modport slave (
    input  in_valid, a, b, inva, ena, enb, f, cin, use_acc, out_ready,
    output in_ready, out_valid, result, cout, zero, neg, ovf
  );
endinterface

// File: rtl/alu_serial.sv
// Bit-serial ALU: one full-adder/logic slice, LSB first, WIDTH cycles per op.
// Optional accumulator operand source enabled by defining ALU_ACC_EN.
`timescale 1ns/1ps
module alu_serial #(
  parameter int unsigned WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  alu_serial_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             inva_q, inva_d, ena_q, ena_d, enb_q, enb_d;
  logic [1:0]       f_q, f_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             cout_q, cout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] op_a;

`ifdef ALU_ACC_EN
  logic [WIDTH-1:0] acc_q, acc_d;
  assign op_a = bus.use_acc ? acc_q : bus.a;
`else
  logic unused_use_acc;
  assign unused_use_acc = bus.use_acc;
  assign op_a = bus.a;
`endif

  // Single slice evaluated on bit 0 of the shifting operands.
  logic             a_bit, b_bit, r_bit, carry_out, is_arith, last_bit;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    a_bit     = inva_q ? ~a_q[0] : (ena_q & a_q[0]);
    b_bit     = enb_q & b_q[0];
    carry_out = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
    is_arith  = (f_q == 2'b11);
    r_bit     = 1'b0;
    case (f_q)
      2'b00:   r_bit = a_bit & b_bit;
      2'b01:   r_bit = a_bit | b_bit;
      2'b10:   r_bit = ~b_bit;
      default: r_bit = a_bit ^ b_bit ^ carry_q;
    endcase
    res_shift = {r_bit, res_q[WIDTH-1:1]};
    last_bit  = (cnt_q == CntW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    inva_d  = inva_q;
    ena_d   = ena_q;
    enb_d   = enb_q;
    f_d     = f_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
`ifdef ALU_ACC_EN
    acc_d   = acc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = op_a;
          b_d     = bus.b;
          inva_d  = bus.inva;
          ena_d   = bus.ena;
          enb_d   = bus.enb;
          f_d     = bus.f;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        res_d   = res_shift;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_out;
        cnt_d   = cnt_q + CntW'(1);
        if (last_bit) begin
          // carry_q here is the carry into the MSB.
          zero_d  = (res_shift == '0);
          neg_d   = r_bit;
          cout_d  = is_arith & carry_out;
          ovf_d   = is_arith & (carry_q ^ carry_out);
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
`ifdef ALU_ACC_EN
          acc_d   = res_q;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      inva_q  <= 1'b0;
      ena_q   <= 1'b0;
      enb_q   <= 1'b0;
      f_q     <= 2'b00;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef ALU_ACC_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      inva_q  <= inva_d;
      ena_q   <= ena_d;
      enb_q   <= enb_d;
      f_q     <= f_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
`ifdef ALU_ACC_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = res_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;
endmodule
